handshake_4phase_initiator: RTL
===============================

HANDSHAKE_4PHASE_INITIATOR -- requirements
Module: handshake_4phase_initiator

Interface
REQ-001 Parameter DataWidth, default 32, width of the transferred payload.
REQ-002 Parameter SyncStages, default 0, number of flip-flop stages on ack_i; 0 means isochronous responder with the path covered by STA; legal range 0..3.
REQ-003 Parameter TimeoutCycles, default 0, watchdog limit in cycles per handshake phase; 0 disables the watchdog.
REQ-004 clk_i  input  1  single clock; every output is registered or decoded from state on this clock.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 valid_i  input  1  upstream stream valid.
REQ-007 ready_o  output  1  upstream stream ready.
REQ-008 data_i  input  DataWidth  upstream payload.
REQ-009 req_o  output  1  4-phase request to the responder.
REQ-010 ack_i  input  1  4-phase acknowledge from the responder.
REQ-011 data_o  output  DataWidth  payload presented to the responder.
REQ-012 busy_o  output  1  high while a handshake is in progress.
REQ-013 error_o  output  1  sticky flag: protocol violation.
REQ-014 timeout_o  output  1  sticky flag: watchdog expired.
REQ-015 clear_i  input  1  clears error_o and timeout_o.

Function
REQ-016 Internal ack_s SHALL be ack_i when SyncStages=0; otherwise ack_i delayed by SyncStages flip-flops.
REQ-017 FSM states: IDLE, REQ (req high, waiting for ack high), REL (req low, waiting for ack low).
REQ-018 IDLE: ready_o=1, req_o=0; on valid_i&&ready_o, data_i is captured into data_o and the FSM moves to REQ; req_o rises one cycle after acceptance.
REQ-019 REQ: ready_o=0, req_o=1, data_o held stable; on ack_s=1 the FSM moves to REL, so req_o falls the following cycle.
REQ-020 REL: ready_o=0, req_o=0, data_o held; on ack_s=0 the FSM moves to IDLE.
REQ-021 ready_o SHALL equal (state==IDLE); busy_o SHALL equal (state!=IDLE); neither depends combinationally on ack_i.
REQ-022 At SyncStages=0 with a responder that answers in one cycle, minimum transfer period is 4 cycles: accept, REQ, REL, IDLE.
REQ-023 data_o SHALL change only on acceptance.
REQ-024 error_o SHALL set when ack_s=1 in IDLE, because the responder acknowledged without a request.
REQ-025 Watchdog: a phase counter clears on each state change, counts in REQ and REL, and saturates at TimeoutCycles; reaching TimeoutCycles sets timeout_o. The FSM SHALL keep waiting and never abort.
REQ-026 Counter width is $clog2(TimeoutCycles+1); with TimeoutCycles=0 there is no counter and timeout_o=0.
REQ-027 If clear_i and a set condition coincide, set wins.
REQ-028 valid_i deasserting while ready_o=1 is legal; once valid_i&&!ready_o, valid_i and data_i SHALL stay stable until acceptance (asserted).

Reset
REQ-029 Reset values: state=IDLE, req_o=0, ready_o=1, busy_o=0, data_o=0, error_o=0, timeout_o=0, counter=0, sync stages=0.
REQ-030 Reset mid-handshake forces req_o=0 asynchronously; completing or discarding the responder's pending phase is the responder's responsibility; the payload is lost.

Structure
REQ-031 The state enum typedef and the SyncStages maximum constant SHALL live in package handshake_4phase_pkg.
REQ-032 The ack_i synchronizer SHALL be the existing sync cell, instantiated only when SyncStages>0; no other sub-modules.

Verification
REQ-033 SyncStages=0, one-cycle responder, data_i=0xDEADBEEF accepted at cycle 0 -> req_o=1 at cycle 1, data_o=0xDEADBEEF, req_o=0 at cycle 2, ready_o=1 at cycle 4.
REQ-034 SyncStages=2, back-to-back valid_i with 0x1,0x2,0x3 -> three full req/ack cycles in order; data_o never changes while req_o=1 or the FSM is in REL.
REQ-035 ack_i pulsed high in IDLE -> error_o=1 after SyncStages+1 cycles and stays set; clear_i held one cycle -> error_o=0.
REQ-036 TimeoutCycles=8, responder never acks -> timeout_o=1 after 8 cycles in REQ, req_o stays 1; a later ack completes the transfer normally.
REQ-037 rst_ni asserted while in REQ -> req_o=0 and ready_o=1 immediately; the next acceptance after reset starts a clean handshake.
REQ-038 Random valid_i and random responder delays of 0..20 cycles -> received payload sequence equals sent sequence, with zero error_o assertions.

Source files
------------

// File: rtl/handshake_4phase_pkg.sv
// Shared types and limits for the 4-phase handshake initiator.
// The state encoding lives here so that the top and any monitors agree on it.
package handshake_4phase_pkg;

    localparam int unsigned MaxSyncStages = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/handshake_4phase_initiator_sync.sv
// Flip-flop synchronizer chain for a single-bit level signal.
// The output is the input delayed by Stages clock edges, reset to 0.
module handshake_4phase_initiator_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= '0;
        end else begin
            q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                q[i] <= q[i-1];
            end
        end
    end

    assign q_o = q[Stages-1];

endmodule

// File: rtl/handshake_4phase_initiator.sv
// Valid/ready stream to 4-phase req/ack initiator with optional ack
// synchronizer, sticky protocol-error flag and per-phase watchdog.
module handshake_4phase_initiator
    import handshake_4phase_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned SyncStages    = 0,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 busy_o,
    output logic                 error_o,
    output logic                 timeout_o,
    input  logic                 clear_i
);

    // Out-of-range requests are clamped rather than producing a longer chain.
    localparam int unsigned SyncEff = (SyncStages > MaxSyncStages) ? MaxSyncStages : SyncStages;

    hs_state_e            state_q, state_d;
    logic                 ack_s;
    logic                 accept;
    logic                 error_q;
    logic [DataWidth-1:0] data_q;

    if (SyncEff == 0) begin : g_no_sync
        assign ack_s = ack_i;
    end else begin : g_sync
        handshake_4phase_initiator_sync #(
            .Stages(SyncEff)
        ) u_ack_sync (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (ack_i),
            .q_o   (ack_s)
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (valid_i) state_d = ST_REQ;
            ST_REQ:  if (ack_s)   state_d = ST_REL;
            ST_REL:  if (!ack_s)  state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    assign accept = (state_q == ST_IDLE) && valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     data_q <= '0;
        else if (accept) data_q <= data_i;
    end

    // An ack seen while idle means the responder answered a request never made.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) error_q <= 1'b0;
        else         error_q <= ((state_q == ST_IDLE) && ack_s) || (error_q && !clear_i);
    end

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q != ST_IDLE);
    assign req_o   = (state_q == ST_REQ);
    assign data_o  = data_q;
    assign error_o = error_q;

    if (TimeoutCycles == 0) begin : g_no_wdog
        assign timeout_o = 1'b0;
    end else begin : g_wdog
        localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
        localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            tmo_q, tmo_set;

        // Counter restarts on every phase change and saturates at the limit;
        // the FSM itself never gives up on the responder.
        always_comb begin
            cnt_d = cnt_q;
            if (state_d != state_q)            cnt_d = '0;
            else if (busy_o && cnt_q != Limit) cnt_d = cnt_q + CntW'(1);
        end

        assign tmo_set = busy_o && (state_d == state_q) && (cnt_d == Limit);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tmo_q <= tmo_set || (tmo_q && !clear_i);
            end
        end

        assign timeout_o = tmo_q;
    end

    // Upstream must hold a stalled transfer until it is taken.
    a_upstream_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (valid_i && $stable(data_i))
    );

endmodule
